// File: rtl/up_axi_slave.sv
// AXI4-Lite slave to single-cycle "up" register-bus bridge, independent read and write FSMs.
// Optional macro UP_AXI_TIMEOUT_EN: 32-cycle ack timeout completing with SLVERR.
module up_axi_slave #(
  parameter int AXI_ADDRESS_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         up_axi_awvalid,
  output logic                         up_axi_awready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] up_axi_awaddr,
  input  logic                         up_axi_wvalid,
  output logic                         up_axi_wready,
  input  logic [31:0]                  up_axi_wdata,
  input  logic [3:0]                   up_axi_wstrb,
  output logic                         up_axi_bvalid,
  input  logic                         up_axi_bready,
  output logic [1:0]                   up_axi_bresp,
  input  logic                         up_axi_arvalid,
  output logic                         up_axi_arready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] up_axi_araddr,
  output logic                         up_axi_rvalid,
  input  logic                         up_axi_rready,
  output logic [1:0]                   up_axi_rresp,
  output logic [31:0]                  up_axi_rdata,
  output logic                         up_wreq,
  output logic [AXI_ADDRESS_WIDTH-3:0] up_waddr,
  output logic [31:0]                  up_wdata,
  input  logic                         up_wack,
  output logic                         up_rreq,
  output logic [AXI_ADDRESS_WIDTH-3:0] up_raddr,
  input  logic [31:0]                  up_rdata,
  input  logic                         up_rack
);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic                         r_wacc, r_racc;
  logic                         r_bvalid, w_bvalid_nxt;
  logic [1:0]                   r_bresp, w_bresp_nxt;
  logic                         r_rvalid, w_rvalid_nxt;
  logic [1:0]                   r_rresp, w_rresp_nxt;
  logic [31:0]                  r_rdata, w_rdata_nxt;
  logic [AXI_ADDRESS_WIDTH-3:0] r_waddr, r_raddr;
  logic [31:0]                  r_wdata;
  logic                         w_waccept, w_raccept;
  logic                         w_wto, w_rto;
  logic                         w_unused;

  assign w_unused  = ^{up_axi_wstrb, up_axi_awaddr[1:0], up_axi_araddr[1:0]};
  assign w_waccept = (r_wstate == W_IDLE) && up_axi_awvalid && up_axi_wvalid;
  assign w_raccept = (r_rstate == R_IDLE) && up_axi_arvalid;

`ifdef UP_AXI_TIMEOUT_EN
  logic [4:0] r_wcnt, r_rcnt;

  // Counters start on the cycle after the request pulse; count 31 is the 32nd wait cycle.
  assign w_wto = (r_wstate == W_WAIT) && !r_wacc && (r_wcnt == 5'd31);
  assign w_rto = (r_rstate == R_WAIT) && !r_racc && (r_rcnt == 5'd31);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wcnt <= '0;
      r_rcnt <= '0;
    end else begin
      if (w_waccept) r_wcnt <= '0;
      else if ((r_wstate == W_WAIT) && !r_wacc) r_wcnt <= r_wcnt + 5'd1;
      if (w_raccept) r_rcnt <= '0;
      else if ((r_rstate == R_WAIT) && !r_racc) r_rcnt <= r_rcnt + 5'd1;
    end
  end
`else
  assign w_wto = 1'b0;
  assign w_rto = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_wacc   <= 1'b0;
      r_racc   <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
      r_rvalid <= 1'b0;
      r_rresp  <= 2'b00;
      r_rdata  <= '0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_raddr  <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      r_wacc   <= w_waccept;
      r_racc   <= w_raccept;
      r_bvalid <= w_bvalid_nxt;
      r_bresp  <= w_bresp_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rresp  <= w_rresp_nxt;
      r_rdata  <= w_rdata_nxt;
      if (w_waccept) begin
        r_waddr <= up_axi_awaddr[AXI_ADDRESS_WIDTH-1:2];
        r_wdata <= up_axi_wdata;
      end
      if (w_raccept) r_raddr <= up_axi_araddr[AXI_ADDRESS_WIDTH-1:2];
    end
  end

  // Acks coinciding with the request pulse (r_wacc/r_racc) are not counted.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_bvalid_nxt = r_bvalid;
    w_bresp_nxt  = r_bresp;
    case (r_wstate)
      W_IDLE: if (w_waccept) w_wstate_nxt = W_WAIT;
      W_WAIT: begin
        if (!r_wacc && up_wack) begin
          w_bvalid_nxt = 1'b1;
          w_bresp_nxt  = 2'b00;
          w_wstate_nxt = W_RESP;
        end else if (w_wto) begin
          w_bvalid_nxt = 1'b1;
          w_bresp_nxt  = 2'b10;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (up_axi_bready) begin
          w_bvalid_nxt = 1'b0;
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rvalid_nxt = r_rvalid;
    w_rresp_nxt  = r_rresp;
    w_rdata_nxt  = r_rdata;
    case (r_rstate)
      R_IDLE: if (w_raccept) w_rstate_nxt = R_WAIT;
      R_WAIT: begin
        if (!r_racc && up_rack) begin
          w_rvalid_nxt = 1'b1;
          w_rresp_nxt  = 2'b00;
          w_rdata_nxt  = up_rdata;
          w_rstate_nxt = R_RESP;
        end else if (w_rto) begin
          w_rvalid_nxt = 1'b1;
          w_rresp_nxt  = 2'b10;
          w_rdata_nxt  = '0;
          w_rstate_nxt = R_RESP;
        end
      end
      R_RESP: begin
        if (up_axi_rready) begin
          w_rvalid_nxt = 1'b0;
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign up_axi_awready = r_wacc;
  assign up_axi_wready  = r_wacc;
  assign up_wreq        = r_wacc;
  assign up_waddr       = r_waddr;
  assign up_wdata       = r_wdata;
  assign up_axi_bvalid  = r_bvalid;
  assign up_axi_bresp   = r_bresp;
  assign up_axi_arready = r_racc;
  assign up_rreq        = r_racc;
  assign up_raddr       = r_raddr;
  assign up_axi_rvalid  = r_rvalid;
  assign up_axi_rresp   = r_rresp;
  assign up_axi_rdata   = r_rdata;

endmodule

// File: tb/tb_up_axi_slave.sv
// Directed bench for up_axi_slave: vector table of single transactions plus hand-written corner sequences.
module tb_up_axi_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [15:0] awaddr, araddr;
  logic [31:0] wdata, rdata, up_wdata, up_rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        up_wreq, up_wack, up_rreq, up_rack;
  logic [13:0] up_waddr, up_raddr;

  int total = 0;
  int bad = 0;

  up_axi_slave #(.AXI_ADDRESS_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn),
    .up_axi_awvalid(awvalid), .up_axi_awready(awready), .up_axi_awaddr(awaddr),
    .up_axi_wvalid(wvalid), .up_axi_wready(wready), .up_axi_wdata(wdata), .up_axi_wstrb(wstrb),
    .up_axi_bvalid(bvalid), .up_axi_bready(bready), .up_axi_bresp(bresp),
    .up_axi_arvalid(arvalid), .up_axi_arready(arready), .up_axi_araddr(araddr),
    .up_axi_rvalid(rvalid), .up_axi_rready(rready), .up_axi_rresp(rresp), .up_axi_rdata(rdata),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [31:0] data;
    int          ack_dly;
    logic        early;
    int          hold;
    logic [13:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_txn(input vec_t v);
    if (!v.rd) begin
      awvalid = 1'b1; wvalid = 1'b1; awaddr = v.addr; wdata = v.data; wstrb = 4'h3;
      @(negedge clk);
      chk("awready_pulse", {31'd0, awready}, 32'd1);
      chk("wready_pulse", {31'd0, wready}, 32'd1);
      chk("wreq_pulse", {31'd0, up_wreq}, 32'd1);
      chk("up_waddr", {18'd0, up_waddr}, {18'd0, v.exp_addr});
      chk("up_wdata", up_wdata, v.exp_data);
      awvalid = 1'b0; wvalid = 1'b0; awaddr = 16'h0; wdata = 32'h0;
      if (v.early) up_wack = 1'b1;
      for (int i = 1; i <= v.ack_dly; i++) begin
        @(negedge clk);
        up_wack = 1'b0;
        chk("wreq_single", {31'd0, up_wreq}, 32'd0);
        chk("bvalid_before_ack", {31'd0, bvalid}, 32'd0);
        if (i == v.ack_dly) up_wack = 1'b1;
      end
      @(negedge clk);
      up_wack = 1'b0;
      chk("bvalid_set", {31'd0, bvalid}, 32'd1);
      chk("bresp_okay", {30'd0, bresp}, 32'd0);
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("bvalid_clear", {31'd0, bvalid}, 32'd0);
    end else begin
      arvalid = 1'b1; araddr = v.addr;
      @(negedge clk);
      chk("arready_pulse", {31'd0, arready}, 32'd1);
      chk("rreq_pulse", {31'd0, up_rreq}, 32'd1);
      chk("up_raddr", {18'd0, up_raddr}, {18'd0, v.exp_addr});
      arvalid = 1'b0; araddr = 16'h0;
      if (v.early) begin
        up_rack = 1'b1; up_rdata = ~v.data;
      end
      for (int i = 1; i <= v.ack_dly; i++) begin
        @(negedge clk);
        up_rack = 1'b0; up_rdata = 32'h0;
        chk("rreq_single", {31'd0, up_rreq}, 32'd0);
        chk("rvalid_before_ack", {31'd0, rvalid}, 32'd0);
        if (i == v.ack_dly) begin
          up_rack = 1'b1; up_rdata = v.data;
        end
      end
      @(negedge clk);
      up_rack = 1'b0; up_rdata = 32'h5555_AAAA;
      chk("rvalid_set", {31'd0, rvalid}, 32'd1);
      chk("rresp_okay", {30'd0, rresp}, 32'd0);
      chk("rdata", rdata, v.exp_data);
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
        chk("rdata_stable", rdata, v.exp_data);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0; up_rdata = 32'h0;
      chk("rvalid_clear", {31'd0, rvalid}, 32'd0);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready", {31'd0, wready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_wreq", {31'd0, up_wreq}, 32'd0);
    chk("rst_rreq", {31'd0, up_rreq}, 32'd0);
    chk("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_waddr", {18'd0, up_waddr}, 32'd0);
    chk("rst_wdata", up_wdata, 32'd0);
    chk("rst_raddr", {18'd0, up_raddr}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0008, 32'hA5A5_1234, 1, 1'b0, 0, 14'h0002, 32'hA5A5_1234};
    vecs[1] = '{1'b1, 16'h0004, 32'hDEAD_BEEF, 1, 1'b0, 5, 14'h0001, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 16'hFFFC, 32'hFFFF_FFFF, 3, 1'b1, 2, 14'h3FFF, 32'hFFFF_FFFF};
    vecs[3] = '{1'b1, 16'hFFFF, 32'h1234_5678, 4, 1'b1, 0, 14'h3FFF, 32'h1234_5678};
    vecs[4] = '{1'b0, 16'h0003, 32'h0000_0000, 2, 1'b0, 1, 14'h0000, 32'h0000_0000};
    vecs[5] = '{1'b1, 16'h1230, 32'h0BAD_F00D, 2, 1'b0, 0, 14'h048C, 32'h0BAD_F00D};

    resetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awaddr = 16'h0; araddr = 16'h0; wdata = 32'h0; wstrb = 4'h0;
    up_wack = 1'b0; up_rack = 1'b0; up_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset_state();
    resetn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) do_txn(vecs[k]);

    // awvalid alone must not start a write
    awvalid = 1'b1; awaddr = 16'h0040; wdata = 32'h0000_0077;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("aw_alone_awready", {31'd0, awready}, 32'd0);
      chk("aw_alone_wreq", {31'd0, up_wreq}, 32'd0);
    end
    chk("waddr_retained", {18'd0, up_waddr}, 32'd0);
    wvalid = 1'b1;
    @(negedge clk);
    chk("aw_w_wreq", {31'd0, up_wreq}, 32'd1);
    chk("aw_w_waddr", {18'd0, up_waddr}, 32'h0010);
    chk("aw_w_wdata", up_wdata, 32'h0000_0077);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    up_wack = 1'b1;
    @(negedge clk);
    up_wack = 1'b0;
    chk("aw_w_bvalid", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("aw_w_bclear", {31'd0, bvalid}, 32'd0);

    // concurrent write (ack after 1) and read (ack after 3)
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 16'h0020; wdata = 32'hCAFE_0001;
    arvalid = 1'b1; araddr = 16'h0030;
    @(negedge clk);
    chk("cc_wreq", {31'd0, up_wreq}, 32'd1);
    chk("cc_rreq", {31'd0, up_rreq}, 32'd1);
    chk("cc_waddr", {18'd0, up_waddr}, 32'h0008);
    chk("cc_raddr", {18'd0, up_raddr}, 32'h000C);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    up_wack = 1'b1;
    @(negedge clk);
    up_wack = 1'b0;
    chk("cc_bvalid", {31'd0, bvalid}, 32'd1);
    chk("cc_rvalid_early", {31'd0, rvalid}, 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("cc_bclear", {31'd0, bvalid}, 32'd0);
    chk("cc_rvalid_wait", {31'd0, rvalid}, 32'd0);
    up_rack = 1'b1; up_rdata = 32'h600D_D00D;
    @(negedge clk);
    up_rack = 1'b0; up_rdata = 32'h0;
    chk("cc_rvalid", {31'd0, rvalid}, 32'd1);
    chk("cc_rdata", rdata, 32'h600D_D00D);
    chk("cc_bvalid_idle", {31'd0, bvalid}, 32'd0);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("cc_rclear", {31'd0, rvalid}, 32'd0);

    // reset while the write waits for its ack
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 16'h0100; wdata = 32'h1111_2222;
    @(negedge clk);
    chk("rw_wreq", {31'd0, up_wreq}, 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk_reset_state();
    resetn = 1'b1; up_wack = 1'b1;
    @(negedge clk);
    up_wack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rw_no_bvalid", {31'd0, bvalid}, 32'd0);
      @(negedge clk);
    end
    do_txn(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule
